// File: rtl/id_ex_pipe_reg_if.sv
// id_ex_pipe_reg_if: decode-to-execute pipeline register bundle (D inputs, E outputs, stall/flush, bubble counter)
interface id_ex_pipe_reg_if #(parameter int XLEN = 32, parameter int CNT_W = 16);
  logic StallE, FlushE, ValidD, ValidE;
  logic [XLEN-1:0] PCD, PCPlus4D, RD1D, RD2D, ImmExtD;
  logic [XLEN-1:0] PCE, PCPlus4E, RD1E, RD2E, ImmExtE;
  logic [4:0] Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE;
  logic RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD;
  logic RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [1:0] ResultSrcD, ResultSrcE;
  logic [2:0] ALUControlD, ALUControlE;
  logic [CNT_W-1:0] BubbleCount;
  modport master (
    output StallE, FlushE, ValidD, PCD, PCPlus4D, RD1D, RD2D, ImmExtD, Rs1D, Rs2D, RdD,
           RegWriteD, ResultSrcD, MemWriteD, JumpD, BranchD, ALUControlD, ALUSrcD,
    input  ValidE, PCE, PCPlus4E, RD1E, RD2E, ImmExtE, Rs1E, Rs2E, RdE,
           RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUControlE, ALUSrcE, BubbleCount
  );
  modport slave (
    input  StallE, FlushE, ValidD, PCD, PCPlus4D, RD1D, RD2D, ImmExtD, Rs1D, Rs2D, RdD,
           RegWriteD, ResultSrcD, MemWriteD, JumpD, BranchD, ALUControlD, ALUSrcD,
    output ValidE, PCE, PCPlus4E, RD1E, RD2E, ImmExtE, Rs1E, Rs2E, RdE,
           RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUControlE, ALUSrcE, BubbleCount
  );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg: ID/EX pipeline register with stall, flush/bubble insertion and saturating bubble counter
module id_ex_pipe_reg #(
  parameter int XLEN = 32,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic reset,
  id_ex_pipe_reg_if.slave bus
);
  typedef struct packed {
    logic valid;
    logic [XLEN-1:0] pc, pc4, rd1, rd2, imm;
    logic [4:0] rs1, rs2, rd;
    logic reg_write;
    logic [1:0] result_src;
    logic mem_write, jump, branch;
    logic [2:0] alu_control;
    logic alu_src;
  } stage_t;
  stage_t d, e;
  logic [CNT_W-1:0] cnt;
  logic bubble;
  always_comb begin
    d = '{valid: 1'b1, pc: bus.PCD, pc4: bus.PCPlus4D, rd1: bus.RD1D, rd2: bus.RD2D, imm: bus.ImmExtD,
          rs1: bus.Rs1D, rs2: bus.Rs2D, rd: bus.RdD, reg_write: bus.RegWriteD, result_src: bus.ResultSrcD,
          mem_write: bus.MemWriteD, jump: bus.JumpD, branch: bus.BranchD, alu_control: bus.ALUControlD,
          alu_src: bus.ALUSrcD};
    bubble = bus.FlushE | (~bus.StallE & ~bus.ValidD);
  end
  // an all-zero stage is the bubble: specifiers clear too so x0 never forwards
  always_ff @(posedge clk) begin
    if (reset) begin
      e <= '0;
      cnt <= '0;
    end else if (bubble) begin
      e <= '0;
      cnt <= cnt + {{(CNT_W-1){1'b0}}, ~&cnt};
    end else if (!bus.StallE) begin
      e <= d;
    end
  end
  assign bus.ValidE = e.valid;
  assign bus.PCE = e.pc;
  assign bus.PCPlus4E = e.pc4;
  assign bus.RD1E = e.rd1;
  assign bus.RD2E = e.rd2;
  assign bus.ImmExtE = e.imm;
  assign bus.Rs1E = e.rs1;
  assign bus.Rs2E = e.rs2;
  assign bus.RdE = e.rd;
  assign bus.RegWriteE = e.reg_write;
  assign bus.ResultSrcE = e.result_src;
  assign bus.MemWriteE = e.mem_write;
  assign bus.JumpE = e.jump;
  assign bus.BranchE = e.branch;
  assign bus.ALUControlE = e.alu_control;
  assign bus.ALUSrcE = e.alu_src;
  assign bus.BubbleCount = cnt;
endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb_id_ex_pipe_reg: directed and random checks of id_ex_pipe_reg against a record-level reference model
module tb_id_ex_pipe_reg;
  localparam int XLEN = 32;
  localparam int CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  typedef struct packed {
    logic valid;
    logic [XLEN-1:0] pc, pc4, rd1, rd2, imm;
    logic [4:0] rs1, rs2, rd;
    logic reg_write;
    logic [1:0] result_src;
    logic mem_write, jump, branch;
    logic [2:0] alu_control;
    logic alu_src;
  } rec_t;
  logic clk = 0;
  logic rst, stall, flush;
  rec_t din, exp_rec;
  int exp_cnt;
  int ncmp = 0, nerr = 0;
  id_ex_pipe_reg_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();
  id_ex_pipe_reg #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (.clk(clk), .reset(rst), .bus(bus));
  always #5 clk = ~clk;
  assign bus.StallE = stall;
  assign bus.FlushE = flush;
  assign bus.ValidD = din.valid;
  assign bus.PCD = din.pc;
  assign bus.PCPlus4D = din.pc4;
  assign bus.RD1D = din.rd1;
  assign bus.RD2D = din.rd2;
  assign bus.ImmExtD = din.imm;
  assign bus.Rs1D = din.rs1;
  assign bus.Rs2D = din.rs2;
  assign bus.RdD = din.rd;
  assign bus.RegWriteD = din.reg_write;
  assign bus.ResultSrcD = din.result_src;
  assign bus.MemWriteD = din.mem_write;
  assign bus.JumpD = din.jump;
  assign bus.BranchD = din.branch;
  assign bus.ALUControlD = din.alu_control;
  assign bus.ALUSrcD = din.alu_src;
  function automatic rec_t observed();
    return '{valid: bus.ValidE, pc: bus.PCE, pc4: bus.PCPlus4E, rd1: bus.RD1E, rd2: bus.RD2E, imm: bus.ImmExtE,
             rs1: bus.Rs1E, rs2: bus.Rs2E, rd: bus.RdE, reg_write: bus.RegWriteE, result_src: bus.ResultSrcE,
             mem_write: bus.MemWriteE, jump: bus.JumpE, branch: bus.BranchE, alu_control: bus.ALUControlE,
             alu_src: bus.ALUSrcE};
  endfunction
  function automatic rec_t rand_rec();
    rec_t r;
    r.valid = ($urandom_range(3) != 0);
    r.pc = $urandom;
    r.pc4 = r.pc + 4;
    r.rd1 = $urandom;
    r.rd2 = $urandom;
    r.imm = $urandom;
    r.rs1 = 5'($urandom);
    r.rs2 = 5'($urandom);
    r.rd = 5'($urandom);
    r.reg_write = 1'($urandom);
    r.result_src = 2'($urandom);
    r.mem_write = 1'($urandom);
    r.jump = 1'($urandom);
    r.branch = 1'($urandom);
    r.alu_control = 3'($urandom);
    r.alu_src = 1'($urandom);
    return r;
  endfunction
  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // one clock edge: model applies the priority rules, then the whole E stage and counter are compared
  task automatic step(input string tag);
    @(posedge clk);
    if (rst) begin
      exp_rec = '0;
      exp_cnt = 0;
    end else if (flush || (!stall && !din.valid)) begin
      exp_rec = '0;
      if (exp_cnt < CNT_MAX) exp_cnt++;
    end else if (!stall) begin
      exp_rec = din;
      exp_rec.valid = 1'b1;
    end
    #1;
    check({tag, "_rec"}, 256'(observed()), 256'(exp_rec));
    check({tag, "_cnt"}, 256'(bus.BubbleCount), 256'(exp_cnt));
  endtask
  initial begin
    exp_rec = '0;
    exp_cnt = 0;
    stall = 0;
    flush = 0;
    rst = 1;
    din = rand_rec();
    din.valid = 1;
    din.rd = 5;
    din.reg_write = 1;
    step("reset0");
    step("reset1");
    check("reset_rde", 256'(bus.RdE), 256'(0));
    check("reset_regwrite", 256'(bus.RegWriteE), 256'(0));
    rst = 0;
    din = '0;
    din.valid = 1;
    din.pc = 32'h100;
    din.rd1 = 32'hDEADBEEF;
    din.rs1 = 3;
    din.rd = 7;
    din.reg_write = 1;
    din.alu_control = 3'b010;
    step("pass");
    check("pass_pce", 256'(bus.PCE), 256'(32'h100));
    check("pass_rd1e", 256'(bus.RD1E), 256'(32'hDEADBEEF));
    check("pass_rs1e", 256'(bus.Rs1E), 256'(3));
    check("pass_rde", 256'(bus.RdE), 256'(7));
    check("pass_valide", 256'(bus.ValidE), 256'(1));
    check("pass_alu", 256'(bus.ALUControlE), 256'(3'b010));
    stall = 1;
    din.rd = 9;
    for (int i = 0; i < 3; i++) begin
      step("stall");
      check("stall_rde", 256'(bus.RdE), 256'(7));
    end
    stall = 0;
    step("unstall");
    check("unstall_rde", 256'(bus.RdE), 256'(9));
    check("unstall_cnt", 256'(bus.BubbleCount), 256'(0));
    stall = 1;
    flush = 1;
    din.mem_write = 1;
    step("flushstall");
    check("flush_regwrite", 256'(bus.RegWriteE), 256'(0));
    check("flush_memwrite", 256'(bus.MemWriteE), 256'(0));
    check("flush_rde", 256'(bus.RdE), 256'(0));
    check("flush_valide", 256'(bus.ValidE), 256'(0));
    check("flush_cnt", 256'(bus.BubbleCount), 256'(1));
    stall = 0;
    flush = 0;
    din.valid = 0;
    din.rd = 4;
    step("invalid");
    check("invalid_rde", 256'(bus.RdE), 256'(0));
    check("invalid_regwrite", 256'(bus.RegWriteE), 256'(0));
    check("invalid_cnt", 256'(bus.BubbleCount), 256'(2));
    for (int i = 0; i < 300; i++) begin
      din = rand_rec();
      stall = ($urandom_range(3) == 0);
      flush = ($urandom_range(7) == 0);
      rst = ($urandom_range(49) == 0);
      step("rand");
    end
    rst = 1;
    stall = 0;
    flush = 0;
    step("satreset");
    rst = 0;
    flush = 1;
    for (int i = 0; i < 20; i++) begin
      din = rand_rec();
      stall = 1'($urandom);
      step("sat");
      check("sat_cnt", 256'(bus.BubbleCount), 256'((i + 1 > 15) ? 15 : i + 1));
    end
    flush = 0;
    rst = 1;
    step("finalreset");
    check("finalreset_cnt", 256'(bus.BubbleCount), 256'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
